// File: rtl/datapath_run_ctrl.sv
// Run sequencer for the datapath core: loads a program image into data and instruction
// memory, runs the core for a cycle budget or until halt, then streams back a data window.
module datapath_run_ctrl #(
  parameter int DADDR_W = 8,
  parameter int IADDR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DADDR_W-1:0] num_data,
  input  logic [IADDR_W-1:0] num_instr,
  input  logic [CNT_W-1:0]   run_cycles,
  input  logic [DADDR_W-1:0] rb_base,
  input  logic [DADDR_W-1:0] rb_count,
  input  logic               halt,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [63:0]        s_data,
  output logic [IADDR_W-1:0] i_mem_addra,
  output logic [31:0]        i_mem_din,
  output logic               i_mem_we,
  output logic [DADDR_W-1:0] d_mem_addra,
  output logic [63:0]        d_mem_din,
  output logic               d_mem_we,
  input  logic [63:0]        d_mem_out,
  output logic               core_reset_n,
  output logic               pc_en,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [63:0]        m_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [3:0] {
    IDLE, LOAD_D, LOAD_I, REL, RUN, RB_ADDR, RB_WAIT, RB_OUT, FIN
  } state_t;

  localparam logic [DADDR_W-1:0] D_ONE = DADDR_W'(1);
  localparam logic [IADDR_W-1:0] I_ONE = IADDR_W'(1);
  localparam logic [CNT_W-1:0]   C_ONE = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [IADDR_W-1:0] load_cnt_reg;
  logic [CNT_W-1:0]   run_cnt_reg;
  logic [DADDR_W-1:0] rb_idx_reg;
  logic [DADDR_W-1:0] num_data_reg, rb_base_reg, rb_count_reg;
  logic [IADDR_W-1:0] num_instr_reg;
  logic [CNT_W-1:0]   run_cycles_reg;
  logic               pc_en_reg, m_valid_reg;
  logic [63:0]        m_data_reg;

  logic s_fire, m_fire, last_d, last_i, last_rb;

  assign s_fire  = s_valid & s_ready;
  assign m_fire  = m_valid_reg & m_ready;
  assign last_d  = (load_cnt_reg[DADDR_W-1:0] == (num_data_reg - D_ONE));
  assign last_i  = (load_cnt_reg == (num_instr_reg - I_ONE));
  assign last_rb = ((rb_idx_reg + D_ONE) == rb_count_reg);

  always_comb begin
    state_next  = state_reg;
    s_ready     = 1'b0;
    d_mem_we    = 1'b0;
    d_mem_addra = '0;
    d_mem_din   = '0;
    i_mem_we    = 1'b0;
    i_mem_addra = '0;
    i_mem_din   = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (num_data != '0)       state_next = LOAD_D;
          else if (num_instr != '0) state_next = LOAD_I;
          else                      state_next = REL;
        end
      end
      LOAD_D: begin
        s_ready     = 1'b1;
        d_mem_we    = s_valid;
        d_mem_addra = load_cnt_reg[DADDR_W-1:0];
        d_mem_din   = s_data;
        if (s_valid && last_d)
          state_next = (num_instr_reg != '0) ? LOAD_I : REL;
      end
      LOAD_I: begin
        s_ready     = 1'b1;
        i_mem_we    = s_valid;
        i_mem_addra = load_cnt_reg;
        i_mem_din   = s_data[31:0];
        if (s_valid && last_i) state_next = REL;
      end
      REL: begin
        if (run_cycles_reg != '0)    state_next = RUN;
        else if (rb_count_reg != '0) state_next = RB_ADDR;
        else                         state_next = FIN;
      end
      RUN: begin
        // halt on the last budget cycle lands on the same exit as expiry
        if (halt || run_cnt_reg == C_ONE)
          state_next = (rb_count_reg != '0) ? RB_ADDR : FIN;
      end
      RB_ADDR: begin
        d_mem_addra = rb_base_reg + rb_idx_reg;
        state_next  = RB_WAIT;
      end
      RB_WAIT: begin
        d_mem_addra = rb_base_reg + rb_idx_reg;
        state_next  = RB_OUT;
      end
      RB_OUT: begin
        if (m_fire) state_next = last_rb ? FIN : RB_ADDR;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      load_cnt_reg   <= '0;
      run_cnt_reg    <= '0;
      rb_idx_reg     <= '0;
      num_data_reg   <= '0;
      num_instr_reg  <= '0;
      run_cycles_reg <= '0;
      rb_base_reg    <= '0;
      rb_count_reg   <= '0;
      pc_en_reg      <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_data_reg     <= '0;
    end else begin
      state_reg <= state_next;
      pc_en_reg <= (state_next == RUN);
      if (state_reg == IDLE && start) begin
        num_data_reg   <= num_data;
        num_instr_reg  <= num_instr;
        run_cycles_reg <= run_cycles;
        rb_base_reg    <= rb_base;
        rb_count_reg   <= rb_count;
        load_cnt_reg   <= '0;
        rb_idx_reg     <= '0;
      end
      // one counter serves both load phases; it restarts at 0 for the instruction image
      if (s_fire)
        load_cnt_reg <= (state_reg == LOAD_D && last_d) ? '0 : load_cnt_reg + I_ONE;
      if (state_reg == REL)
        run_cnt_reg <= run_cycles_reg;
      else if (state_reg == RUN)
        run_cnt_reg <= run_cnt_reg - C_ONE;
      if (state_reg == RB_WAIT) begin
        m_data_reg  <= d_mem_out;
        m_valid_reg <= 1'b1;
      end else if (m_fire) begin
        m_valid_reg <= 1'b0;
        rb_idx_reg  <= rb_idx_reg + D_ONE;
      end
    end
  end

  assign core_reset_n = !(state_reg == IDLE || state_reg == LOAD_D || state_reg == LOAD_I);
  assign pc_en        = pc_en_reg;
  assign m_valid      = m_valid_reg;
  assign m_data       = m_data_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FIN);

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Directed program runs with randomized data, handshakes, halt noise and config noise,
// checked against a handshake-level model of the load/run/readback sequence.
module tb_datapath_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, halt, s_valid, s_ready, m_valid, m_ready;
  logic [7:0]  num_data, rb_base, rb_count, d_mem_addra;
  logic [31:0] num_instr, run_cycles, i_mem_addra, i_mem_din;
  logic [63:0] s_data, d_mem_din, d_mem_out, m_data;
  logic        i_mem_we, d_mem_we, core_reset_n, pc_en, busy, done;

  int n_cmp, n_fail;
  logic [63:0] ref_dmem [256];
  logic [63:0] dmem_env [256];
  bit          dmem_wr  [256];

  always #5 clk = ~clk;

  datapath_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .num_data(num_data), .num_instr(num_instr), .run_cycles(run_cycles),
    .rb_base(rb_base), .rb_count(rb_count), .halt(halt),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .i_mem_addra(i_mem_addra), .i_mem_din(i_mem_din), .i_mem_we(i_mem_we),
    .d_mem_addra(d_mem_addra), .d_mem_din(d_mem_din), .d_mem_we(d_mem_we),
    .d_mem_out(d_mem_out), .core_reset_n(core_reset_n), .pc_en(pc_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done)
  );

  function automatic logic [63:0] pat(input logic [7:0] a);
    return {24'hC0FFEE, a, 24'h5EED00, ~a};
  endfunction

  // Data memory the core would own: 1-cycle registered read, never-written words read as pat()
  always @(posedge clk) begin
    if (d_mem_we) begin
      dmem_env[d_mem_addra] <= d_mem_din;
      dmem_wr[d_mem_addra]  <= 1'b1;
    end
    d_mem_out <= dmem_wr[d_mem_addra] ? dmem_env[d_mem_addra] : pat(d_mem_addra);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({core_reset_n, pc_en, s_ready, m_valid, done, busy, i_mem_we, d_mem_we}), 64'(0));
    chk({tag, "_m_data"}, m_data, 64'(0));
    chk({tag, "_mem_addr"}, 64'({i_mem_addra, d_mem_addra}), 64'(0));
    chk({tag, "_mem_din"}, d_mem_din | 64'(i_mem_din), 64'(0));
  endtask

  task automatic run_prog(input int nd, input int ni, input int rc, input int base, input int cnt,
                          input bit bp, input int halt_at, input int abort_i);
    logic [63:0] words [$];
    logic [63:0] prev_m;
    int cyc, h, dw, iw, pc_cyc, done_cnt, both_we, rd_idx;
    int stall_left, stall_seen, stall_bad, sready_bad;
    int rel_cyc, pc_first, done_cyc, exp_pc;
    bit prev_stall, finished, aborted;
    for (int k = 0; k < nd + ni; k++) words.push_back({$urandom, $urandom});
    cyc = 0; h = 0; dw = 0; iw = 0; pc_cyc = 0; done_cnt = 0; both_we = 0; rd_idx = 0;
    stall_seen = 0; stall_bad = 0; sready_bad = 0;
    rel_cyc = -1; pc_first = -1; done_cyc = -1;
    prev_m = '0; prev_stall = 1'b0; finished = 1'b0; aborted = 1'b0;
    stall_left = bp ? 5 : 0;
    exp_pc = (halt_at > 0 && halt_at < rc) ? halt_at : rc;
    while (!finished && cyc < 5000) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b1; num_data = 8'(nd); num_instr = 32'(ni); run_cycles = 32'(rc);
        rb_base = 8'(base); rb_count = 8'(cnt);
      end else begin
        // configuration and start noise while busy must be ignored
        start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        num_data = 8'($urandom); num_instr = $urandom; run_cycles = $urandom;
        rb_base = 8'($urandom); rb_count = 8'($urandom);
      end
      s_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = (h < nd + ni) ? words[h] : {$urandom, $urandom};
      halt    = pc_en ? (halt_at > 0 && pc_cyc == halt_at - 1) : 1'($urandom_range(0, 1));
      m_ready = !(m_valid && stall_left > 0);
      #1;
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'(1));
      if (d_mem_we && i_mem_we) both_we++;
      if (core_reset_n && s_ready) sready_bad++;
      if (s_valid && s_ready) begin
        if (h < nd) begin
          chk("d_we", 64'(d_mem_we), 64'(1));
          chk("d_addr", 64'(d_mem_addra), 64'(h));
          chk("d_din", d_mem_din, words[h]);
          ref_dmem[8'(h)] = words[h];
        end else begin
          chk("i_we", 64'(i_mem_we), 64'(1));
          chk("i_addr", 64'(i_mem_addra), 64'(h - nd));
          chk("i_din", 64'(i_mem_din), 64'(words[h][31:0]));
        end
        h++;
      end
      if (d_mem_we) dw++;
      if (i_mem_we) iw++;
      if (core_reset_n && rel_cyc < 0) rel_cyc = cyc;
      if (pc_en) begin
        if (pc_first < 0) pc_first = cyc;
        pc_cyc++;
      end
      if (m_valid && !m_ready) begin
        if (prev_stall && m_data !== prev_m) stall_bad++;
        prev_m = m_data; prev_stall = 1'b1; stall_left--; stall_seen++;
      end else begin
        prev_stall = 1'b0;
      end
      if (m_valid && m_ready) begin
        chk("rb_data", m_data, ref_dmem[8'(base + rd_idx)]);
        rd_idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("core_rst_after_done", 64'(core_reset_n), 64'(0));
        finished = 1'b1;
      end
      if (abort_i > 0 && iw == abort_i) begin
        @(posedge clk);
        #2;
        reset = 1'b1; start = 1'b0;
        #1;
        chk_reset("abort");
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        @(negedge clk);
        @(negedge clk);
        chk("abort_done_low", 64'(done), 64'(0));
        reset = 1'b0; s_valid = 1'b0;
        aborted = 1'b1; finished = 1'b1;
      end
      cyc++;
    end
    chk("run_complete", 64'(finished), 64'(1));
    if (!aborted) begin
      chk("handshakes", 64'(h), 64'(nd + ni));
      chk("d_writes", 64'(dw), 64'(nd));
      chk("i_writes", 64'(iw), 64'(ni));
      chk("we_overlap", 64'(both_we), 64'(0));
      chk("s_ready_late", 64'(sready_bad), 64'(0));
      chk("pc_cycles", 64'(pc_cyc), 64'(exp_pc));
      if (exp_pc > 0) chk("rst_lead", 64'(pc_first - rel_cyc), 64'(1));
      if (rc == 0 && cnt == 0) chk("rel_to_done", 64'(done_cyc - rel_cyc), 64'(1));
      chk("rb_words", 64'(rd_idx), 64'(cnt));
      chk("done_pulses", 64'(done_cnt), 64'(1));
      if (bp && cnt > 0) begin
        chk("stall_cycles", 64'(stall_seen), 64'(5));
        chk("stall_stable", 64'(stall_bad), 64'(0));
      end
    end
    $display("run nd=%0d ni=%0d rc=%0d base=%0d cnt=%0d bp=%0d halt_at=%0d abort=%0d: pc=%0d rb=%0d done=%0d",
             nd, ni, rc, base, cnt, bp, halt_at, abort_i, pc_cyc, rd_idx, done_cnt);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; halt = 1'b0; s_valid = 1'b1; s_data = '1; m_ready = 1'b1;
    num_data = '0; num_instr = '0; run_cycles = '0; rb_base = '0; rb_count = '0;
    for (int a = 0; a < 256; a++) ref_dmem[a] = pat(8'(a));
    #3;
    chk_reset("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_prog(39, 174, 51, 1, 4, 1'b0, 0, 0);    // full run
    run_prog(20, 30, 8, 3, 3, 1'b1, 0, 0);      // backpressure
    run_prog(10, 10, 100, 0, 2, 1'b0, 10, 0);   // halt on RUN cycle 10
    run_prog(0, 5, 0, 7, 0, 1'b0, 0, 0);        // zero counts
    run_prog(5, 40, 6, 0, 2, 1'b0, 0, 20);      // reset in LOAD_I
    run_prog(6, 25, 3, 0, 6, 1'b0, 0, 0);       // reload from address 0
    run_prog(3, 2, 5, 254, 4, 1'b1, 0, 0);      // readback address wrap
    run_prog(4, 3, 7, 9, 2, 1'b0, 7, 0);        // halt on final budget cycle
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_run_ctrl.md
Name: datapath_run_ctrl

Overview:
- Sequences one complete program run on the datapath core, replacing the manual load/run sequence in the bench.
- A host streams 64-bit words over a valid/ready port. The block writes the first NUM_DATA words into data memory and the next NUM_INSTR words into instruction memory, holding the core in reset throughout.
- It then releases the core reset and asserts pc_en for a programmed cycle budget or until halt.
- Finally it reads back RB_COUNT data-memory words over a valid/ready output stream and returns to idle.

Parameters:
DADDR_W, 8, data-memory address width.
IADDR_W, 32, instruction-memory address width.
CNT_W, 32, run-cycle counter width.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin run; sampled only in IDLE.
num_data  in  DADDR_W  data words to load; latched at start.
num_instr  in  IADDR_W  instruction words to load; latched at start.
run_cycles  in  CNT_W  pc_en budget in cycles; latched at start.
rb_base  in  DADDR_W  first readback address; latched at start.
rb_count  in  DADDR_W  words to read back; latched at start.
halt  in  1  early-stop request from core; sampled in RUN only.
s_valid  in  1  host load word valid.
s_ready  out  1  load word accepted when s_valid and s_ready are both high.
s_data  in  64  load word; instructions use bits [31:0].
i_mem_addra  out  IADDR_W  instruction-memory write address.
i_mem_din  out  32  instruction-memory write data.
i_mem_we  out  1  instruction-memory write enable.
d_mem_addra  out  DADDR_W  data-memory address, used for write and read.
d_mem_din  out  64  data-memory write data.
d_mem_we  out  1  data-memory write enable.
d_mem_out  in  64  data-memory read data; 1-cycle read latency.
core_reset_n  out  1  drives the datapath reset_n.
pc_en  out  1  datapath PC enable.
m_valid  out  1  readback word valid.
m_ready  in  1  readback sink ready.
m_data  out  64  readback word.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (asynchronous) values:
  - state=IDLE; all counters 0.
  - core_reset_n=0; pc_en=0; s_ready=0; m_valid=0; m_data=0; done=0.
  - Memory address/data/enable outputs all 0.
  - Memory contents are untouched.
- Reset mid-operation aborts immediately with no partial completion: done stays 0 and a pending m_valid drops.
- start is ignored outside IDLE. Configuration inputs are latched on the start edge.
- States: IDLE -> LOAD_D -> LOAD_I -> REL -> RUN -> RB_ADDR -> RB_WAIT -> RB_OUT -> (RB_ADDR | FIN) -> IDLE.
- IDLE:
  - core_reset_n=0, s_ready=0.
  - start=1 moves to LOAD_D. If num_data=0, go directly to LOAD_I.
- LOAD_D:
  - s_ready=1.
  - d_mem_we = s_valid & s_ready, combinational, same cycle.
  - d_mem_addra = load counter (starts at 0); d_mem_din = s_data.
  - Counter increments per handshake. The handshake on word num_data-1 moves to LOAD_I.
- LOAD_I:
  - Same rules on the i_mem port: i_mem_din = s_data[31:0], addresses start at 0.
  - The last handshake moves to REL.
  - If num_instr=0, skip LOAD_I and go to REL.
- REL:
  - One cycle with core_reset_n=1 and pc_en=0, so the core leaves reset before fetch.
  - Next state is RUN, or RB_ADDR if run_cycles=0.
- RUN:
  - pc_en=1 (registered) for exactly run_cycles cycles, counted by a down-counter.
  - halt=1 sampled at an edge: pc_en is 0 from the next cycle, and the FSM goes to RB_ADDR.
  - halt on the final budget cycle behaves identically to expiry.
  - core_reset_n stays 1 from REL until return to IDLE.
- Readback:
  - If rb_count=0, go RUN -> FIN.
  - RB_ADDR drives d_mem_addra = rb_base + index. The add wraps modulo 2^DADDR_W.
  - RB_WAIT covers the 1-cycle memory latency.
  - RB_OUT registers d_mem_out into m_data and asserts m_valid. m_data and m_valid hold stable until m_ready.
  - The handshake increments the index. Move to FIN after rb_count words, otherwise back to RB_ADDR.
- FIN: done=1 for one cycle, then IDLE. core_reset_n returns to 0 in IDLE.
- Exclusivity: i_mem_we and d_mem_we are never both high. Memory write enables are 0 outside the LOAD states. s_ready is 0 outside the LOAD states.
- busy is combinational: busy = (state != IDLE).

Test Plan:
- Full run: num_data=39, num_instr=174, run_cycles=51, rb_base=1, rb_count=4, no stalls.
  - Required: 39 d_mem writes at addresses 0..38, then 174 i_mem writes at 0..173.
  - Required: core_reset_n rises 1 cycle before pc_en; pc_en is high exactly 51 cycles.
  - Required: m_data equals the words loaded at addresses 1..4; one done pulse.
- Backpressure: toggle s_valid randomly and hold m_ready=0 for 5 cycles in RB_OUT.
  - Required: the write count equals the handshake count.
  - Required: m_data stays constant while stalled, and no word is lost or duplicated.
- Halt: run_cycles=100 with halt asserted on RUN cycle 10.
  - Required: pc_en high for exactly 10 cycles, then readback proceeds.
- Zero counts: num_data=0, run_cycles=0, rb_count=0.
  - Required: no d_mem writes, pc_en never high, done 1 cycle after REL+FIN, busy drops.
- Wrap: rb_base=254, rb_count=4 with DADDR_W=8.
  - Required: read addresses are 254, 255, 0, 1.
- Reset in LOAD_I after 20 instructions.
  - Required: all outputs return to reset values asynchronously and done is never asserted.
  - Required: a new start reloads from address 0.
